// File: rtl/lvds_tx_link_ctrl.sv
// lvds_tx_link_ctrl: transmit link controller for one LVDS serializer lane.
// Trains the link with TRAIN_WORD, then shares the single serializer word slot
// among NUM_REQ requesters round-robin. When nothing is pending, IDLE_WORD fills
// the slot, so the lane always carries a valid framed word once out of reset.
module lvds_tx_link_ctrl #(
  parameter int                    NUM_REQ    = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] TRAIN_WORD = 8'hA5,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = 8'h3C,
  parameter int                    TRAIN_LEN  = 16,
  localparam int                   GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_sys,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         ser_data,
  output logic                          ser_valid,
  input  logic                          ser_ready,
  input  logic                          link_up,
  output logic                          link_active,
  output logic [GW-1:0]                 grant_id
);

  localparam int CW = $clog2(TRAIN_LEN + 1);

  localparam logic [0:0] ST_TRAIN  = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [CW-1:0]         train_cnt_q, train_cnt_d;
  logic [GW-1:0]         grant_id_q, grant_id_d;
  logic [DATA_WIDTH-1:0] ser_data_q, ser_data_d;
  logic                  ser_valid_q, ser_valid_d;

  logic                  load_en;
  logic                  found;
  logic [GW-1:0]         win;
  logic [GW-1:0]         cand;
  logic [NUM_REQ-1:0]    grant;

  // The output register may take a new word when empty or when the serializer drains it.
  assign load_en = !ser_valid_q || ser_ready;

  // Round-robin search: first valid requester after the last grant, wrapping.
  always_comb begin
    found = 1'b0;
    win   = grant_id_q;
    cand  = grant_id_q;
    grant = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(grant_id_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    if (found) grant[win] = 1'b1;
  end

  // Handshake back to requesters only on a real ACTIVE load with the link up.
  assign req_ready = (state_q == ST_ACTIVE && link_up && load_en) ? grant : '0;

  // Next-state: training counter, state transitions and output word selection.
  // The word loaded on an edge is chosen from the pre-transition state.
  always_comb begin
    state_d     = state_q;
    train_cnt_d = train_cnt_q;
    grant_id_d  = grant_id_q;
    ser_data_d  = ser_data_q;
    ser_valid_d = ser_valid_q;
    if (state_q == ST_TRAIN) begin
      if (ser_valid_q && ser_ready && train_cnt_q != CW'(TRAIN_LEN))
        train_cnt_d = train_cnt_q + 1'b1;
      if (train_cnt_q == CW'(TRAIN_LEN) && link_up)
        state_d = ST_ACTIVE;
      if (load_en) begin
        ser_data_d  = TRAIN_WORD;
        ser_valid_d = 1'b1;
      end
    end else if (!link_up) begin
      // Any link drop, however short, forces a full retraining.
      state_d     = ST_TRAIN;
      train_cnt_d = '0;
      if (load_en) begin
        ser_data_d  = TRAIN_WORD;
        ser_valid_d = 1'b1;
      end
    end else if (load_en) begin
      ser_valid_d = 1'b1;
      if (found) begin
        ser_data_d = req_data[win*DATA_WIDTH +: DATA_WIDTH];
        grant_id_d = win;
      end else begin
        ser_data_d = IDLE_WORD;
      end
    end
  end

  // State registers; grant pointer resets to the last index so requester 0 goes first.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_TRAIN;
      train_cnt_q <= '0;
      grant_id_q  <= GW'(NUM_REQ - 1);
      ser_data_q  <= '0;
      ser_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      train_cnt_q <= train_cnt_d;
      grant_id_q  <= grant_id_d;
      ser_data_q  <= ser_data_d;
      ser_valid_q <= ser_valid_d;
    end
  end

  assign ser_data    = ser_data_q;
  assign ser_valid   = ser_valid_q;
  assign grant_id    = grant_id_q;
  assign link_active = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_lvds_tx_link_ctrl.sv
// Bench for lvds_tx_link_ctrl: directed phases plus a randomized phase, all
// checked every cycle against a word-level reference model of the link rules.
module tb_lvds_tx_link_ctrl;
  localparam int         N  = 4;
  localparam int         DW = 8;
  localparam int         TL = 16;
  localparam logic [7:0] TW = 8'hA5;
  localparam logic [7:0] IW = 8'h3C;

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      req_ready;
  logic [DW-1:0]     ser_data;
  logic              ser_valid;
  logic              ser_ready = 1'b0;
  logic              link_up = 1'b0;
  logic              link_active;
  logic [1:0]        grant_id;

  lvds_tx_link_ctrl #(.NUM_REQ(N), .DATA_WIDTH(DW), .TRAIN_WORD(TW), .IDLE_WORD(IW),
                      .TRAIN_LEN(TL)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .ser_data(ser_data), .ser_valid(ser_valid),
    .ser_ready(ser_ready), .link_up(link_up), .link_active(link_active),
    .grant_id(grant_id));

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: link mode, accepted training words, rotation pointer, output slot.
  bit         m_active;
  int         m_trained;
  int         m_ptr;
  logic [7:0] m_data;
  bit         m_valid;
  int         last_g;
  logic [7:0] rq [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_active = 0; m_trained = 0; m_ptr = N - 1; m_data = '0; m_valid = 0; last_g = -1;
  endtask

  // One clock: check the combinational handshake, advance the model, check outputs.
  task automatic step();
    bit           load;
    int           g;
    logic [N-1:0] exp_rdy;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = rq[i];
    #1;
    load    = !m_valid || ser_ready;
    g       = -1;
    exp_rdy = '0;
    if (m_active && link_up && load)
      for (int d = 1; d <= N; d++)
        if (g < 0 && req_valid[(m_ptr + d) % N]) g = (m_ptr + d) % N;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    last_g = g;
    if (!m_active) begin
      bit go;
      go = (m_trained == TL) && link_up;
      if (m_valid && ser_ready && m_trained < TL) m_trained++;
      if (load) begin m_data = TW; m_valid = 1; end
      if (go) m_active = 1;
    end else if (!link_up) begin
      m_active = 0; m_trained = 0;
      if (load) begin m_data = TW; m_valid = 1; end
    end else if (load) begin
      m_valid = 1;
      if (g >= 0) begin m_data = rq[g]; m_ptr = g; end
      else m_data = IW;
    end
    @(posedge clk_sys); #1;
    chk("ser_valid", 32'(ser_valid), 32'(m_valid));
    chk("ser_data", 32'(ser_data), 32'(m_data));
    chk("grant_id", 32'(grant_id), 32'(m_ptr));
    chk("link_active", 32'(link_active), 32'(m_active));
  endtask

  // Step until link_active, returning the number of steps (bounded).
  task automatic wait_active(output int n);
    n = 0;
    while (!link_active && n < 100) begin step(); n++; end
    if (!link_active) chk("active_timeout", 32'(link_active), 32'd1);
  endtask

  initial begin
    int n;
    mreset();
    for (int i = 0; i < N; i++) rq[i] = 8'h10 + 8'(i);
    req_valid = 4'b1111;
    link_up   = 1'b1;
    ser_ready = 1'b1;
    @(posedge clk_sys); @(posedge clk_sys); #1;
    chk("rst_ser_valid", 32'(ser_valid), 32'd0);
    chk("rst_ser_data", 32'(ser_data), 32'd0);
    chk("rst_link_active", 32'(link_active), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd3);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    reset_n = 1'b1;

    // Training: 16 accepts make the count full after edge 17; ACTIVE rises on edge 18.
    wait_active(n);
    chk("train_edges", 32'(n), 32'(TL + 2));
    chk("last_train_word", 32'(ser_data), 32'(TW));
    step();
    chk("first_idle", 32'(ser_data), 32'(IW));

    // Round-robin with all requesters held valid.
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_data", 32'(ser_data), 32'(8'h10 + 8'(k % N)));
    end

    // Fairness skip: grant 1, then 1010 alternates 3,1,3.
    req_valid = 4'b0010;
    step();
    chk("skip_g1", 32'(grant_id), 32'd1);
    req_valid = 4'b1010;
    step(); chk("skip_g3a", 32'(grant_id), 32'd3);
    step(); chk("skip_g1b", 32'(grant_id), 32'd1);
    step(); chk("skip_g3c", 32'(grant_id), 32'd3);

    // Backpressure: frozen output, no handshake, then the rotation resumes.
    req_valid = 4'b1111;
    step();
    chk("bp_pre_g", 32'(grant_id), 32'd0);
    ser_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold_data", 32'(ser_data), 32'h10);
      chk("bp_hold_g", 32'(grant_id), 32'd0);
    end
    ser_ready = 1'b1;
    step();
    chk("bp_resume", 32'(ser_data), 32'h11);

    // Link loss for one cycle.
    req_valid = 4'b0001;
    link_up   = 1'b0;
    step();
    chk("loss_word", 32'(ser_data), 32'(TW));
    chk("loss_active", 32'(link_active), 32'd0);
    link_up = 1'b1;
    n = 0;
    while (ser_data !== rq[0] && n < 100) begin step(); n++; end
    chk("retrain_steps", 32'(n), 32'(TL + 2));

    // Randomized traffic: requesters hold until accepted, random backpressure and link drops.
    for (int c = 0; c < 400; c++) begin
      ser_ready = ($urandom_range(0, 3) != 0);
      link_up   = ($urandom_range(0, 59) != 0);
      step();
      if (last_g >= 0) begin
        rq[last_g]        = 8'($urandom);
        req_valid[last_g] = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          rq[i]        = 8'($urandom);
        end
    end

    // Reach ACTIVE, then reset mid-transfer with ser_ready low.
    link_up = 1'b1; ser_ready = 1'b1; req_valid = '0;
    wait_active(n);
    step();
    req_valid = 4'b1111;
    ser_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ser_valid), 32'd0);
    chk("mid_rst_active", 32'(link_active), 32'd0);
    chk("mid_rst_grant", 32'(grant_id), 32'd3);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    mreset();
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    ser_ready = 1'b1;
    req_valid = '0;
    step();
    chk("post_rst_train", 32'(ser_data), 32'(TW));
    wait_active(n);
    chk("post_rst_edges", 32'(n), 32'(TL + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
